sipo_deframer: RTL



---
 rtl/sipo_deframer.sv | 85 ++++++++
 1 files changed

// File: rtl/sipo_deframer.sv
// Serial-in parallel-out receive stage: rebuilds LSB-first serial words and
// presents them on a valid/ready output with a sticky overrun flag.
module sipo_deframer #(
  parameter  int WIDTH = 4,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic             sin_en,
  input  logic             align,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             overrun
);

  // Only WIDTH-1 bits are stored; the final bit of a word goes straight to dout.
  logic [WIDTH-2:0] sr_q, sr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;

  logic [WIDTH-1:0] word;
  logic             complete;

  always_comb begin
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    dout_d    = dout_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    word      = {sin, sr_q};
    complete  = 1'b0;

    if (align) begin
      sr_d  = '0;
      cnt_d = '0;
    end else if (sin_en) begin
      sr_d = word[WIDTH-1:1];
      if (cnt_q == CNT_W'(WIDTH - 1)) begin
        complete = 1'b1;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    // A completing word may refill dout in the same cycle it is accepted.
    if (complete) begin
      if (!valid_q || dout_ready) begin
        dout_d  = word;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && dout_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sr_q      <= '0;
      cnt_q     <= '0;
      dout_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      sr_q      <= sr_d;
      cnt_q     <= cnt_d;
      dout_q    <= dout_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = valid_q;
  assign bit_cnt    = cnt_q;
  assign overrun    = overrun_q;

endmodule
